// File: rtl/tt_um_jimktrains_vslc_pkg.sv
// Shared definitions for the VSLC scan sequencer: FSM state encodings and the
// layout of the 4-byte program header at the start of the EEPROM.
package tt_um_jimktrains_vslc_pkg;

    typedef enum logic [2:0] {
        ST_HEADER = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LATCH  = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [15:0] HDR_START_HI = 16'd0;
    localparam logic [15:0] HDR_START_LO = 16'd1;
    localparam logic [15:0] HDR_END_HI   = 16'd2;
    localparam logic [15:0] HDR_END_LO   = 16'd3;
    localparam int          HDR_LEN      = 4;

    function automatic logic is_hdr_addr(input logic [15:0] a);
        return a < 16'(HDR_LEN);
    endfunction

endpackage

// File: rtl/tt_um_jimktrains_vslc_scan_sequencer_if.sv
// Reader/executor bus of the scan sequencer. The sequencer takes the master
// modport; the reader and executor side together take the slave modport.
interface tt_um_jimktrains_vslc_scan_sequencer_if;

    logic        rd_valid;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        exec_busy;
    logic        rd_restart;
    logic [15:0] rd_start_addr;
    logic        rd_hold_n;
    logic        instr_valid;
    logic [7:0]  instr_data;
    logic        in_latch;
    logic        scan_done;

    modport master (
        input  rd_valid, rd_addr, rd_data, exec_busy,
        output rd_restart, rd_start_addr, rd_hold_n,
        output instr_valid, instr_data, in_latch, scan_done
    );

    modport slave (
        output rd_valid, rd_addr, rd_data, exec_busy,
        input  rd_restart, rd_start_addr, rd_hold_n,
        input  instr_valid, instr_data, in_latch, scan_done
    );

endinterface

// File: rtl/tt_um_jimktrains_vslc_scan_trigger.sv
// Scan trigger source: synchronised external edge, periodic auto-trigger and
// free-run retrigger on IDLE entry, merged into a single trig pulse.
module tt_um_jimktrains_vslc_scan_trigger #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig_ext,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                idle_entry,
    output logic                trig
);

    logic [2:0]          sync_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic                ext_edge;
    logic                auto_fire;
    logic                free_fire;

    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], trig_ext};
        end
    end

    assign ext_edge  = sync_q[1] & ~sync_q[2];
    assign auto_fire = auto_en && (period != '0) && (cnt_q == period - PERIOD_W'(1));
    assign free_fire = auto_en && (period == '0) && idle_entry;

    always_ff @(posedge clk) begin
        if (rst || !auto_en || (period == '0) || auto_fire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PERIOD_W'(1);
        end
    end

    assign trig = ext_edge | auto_fire | free_fire;

endmodule

// File: rtl/tt_um_jimktrains_vslc_scan_sequencer.sv
// VSLC scan sequencer: fetches the program header, then per trigger restarts the
// EEPROM reader and forwards start..end bytes. Optional: VSLC_SCAN_WATCHDOG_EN.
module tt_um_jimktrains_vslc_scan_sequencer
    import tt_um_jimktrains_vslc_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int PERIOD_W = 16,
    parameter int WDOG_W   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trig_ext,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period,
    tt_um_jimktrains_vslc_scan_sequencer_if.master bus,
    output logic                overrun,
    output logic                cfg_err
);

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   start_q, end_q;
    logic                restart_q;
    logic                was_idle_q;
    logic                vld_p1, done_p1;
    logic [7:0]          data_p1;
    logic                trig;
    logic                wd_trip;
    logic                hdr_last, hdr_bad, in_range, at_end;
    logic [ADDR_W-1:0]   hdr_end;

    tt_um_jimktrains_vslc_scan_trigger #(.PERIOD_W(PERIOD_W)) u_trig (
        .clk        (clk),
        .rst        (rst),
        .trig_ext   (trig_ext),
        .auto_en    (auto_en),
        .period     (period),
        .idle_entry (state_q == ST_IDLE && !was_idle_q),
        .trig       (trig)
    );

    // The end address is validated against the byte arriving now, before it is registered
    assign hdr_last = bus.rd_valid && (bus.rd_addr == HDR_END_LO);
    assign hdr_end  = {end_q[ADDR_W-1:8], bus.rd_data};
    assign hdr_bad  = (hdr_end == '0) || (hdr_end < start_q);
    assign in_range = bus.rd_valid && (16'(start_q) <= bus.rd_addr) && (bus.rd_addr <= 16'(end_q));
    assign at_end   = bus.rd_valid && (bus.rd_addr == 16'(end_q));

`ifdef VSLC_SCAN_WATCHDOG_EN
    logic [WDOG_W-1:0] wd_q;

    always_ff @(posedge clk) begin
        if (rst || bus.rd_valid || !(state_q == ST_HEADER || state_q == ST_RUN)) begin
            wd_q <= '0;
        end else if (!wd_trip) begin
            wd_q <= wd_q + WDOG_W'(1);
        end
    end

    assign wd_trip = &wd_q;
`else
    assign wd_trip = 1'b0 && (WDOG_W > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HEADER;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        bus.rd_hold_n = 1'b0;
        case (state_q)
            ST_HEADER: begin
                bus.rd_hold_n = 1'b1;
                if (wd_trip) begin
                    state_n = ST_ERROR;
                end else if (hdr_last) begin
                    state_n = hdr_bad ? ST_ERROR : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (trig) begin
                    state_n = ST_LATCH;
                end
            end
            ST_LATCH: begin
                bus.rd_hold_n = 1'b1;
                state_n       = ST_RUN;
            end
            ST_RUN: begin
                bus.rd_hold_n = !bus.exec_busy;
                if (wd_trip) begin
                    state_n = ST_ERROR;
                end else if (at_end) begin
                    state_n = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_n = ST_ERROR;
            end
            default: begin
                state_n = ST_HEADER;
            end
        endcase
    end

    // Stage p1: registered instruction byte, its valid and the end-of-scan marker
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= '0;
            end_q      <= '0;
            restart_q  <= 1'b1;
            was_idle_q <= 1'b0;
            vld_p1     <= 1'b0;
            done_p1    <= 1'b0;
            data_p1    <= '0;
            overrun    <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            restart_q  <= 1'b0;
            was_idle_q <= (state_q == ST_IDLE);
            if (state_q == ST_HEADER && bus.rd_valid && is_hdr_addr(bus.rd_addr)) begin
                if (bus.rd_addr == HDR_START_HI) start_q[ADDR_W-1:8] <= bus.rd_data[ADDR_W-9:0];
                if (bus.rd_addr == HDR_START_LO) start_q[7:0]        <= bus.rd_data;
                if (bus.rd_addr == HDR_END_HI)   end_q[ADDR_W-1:8]   <= bus.rd_data[ADDR_W-9:0];
                if (bus.rd_addr == HDR_END_LO)   end_q[7:0]          <= bus.rd_data;
            end
            vld_p1  <= (state_q == ST_RUN) && in_range;
            done_p1 <= (state_q == ST_RUN) && at_end;
            if (state_q == ST_RUN && in_range) begin
                data_p1 <= bus.rd_data;
            end
            if (trig && (state_q == ST_HEADER || state_q == ST_LATCH || state_q == ST_RUN)) begin
                overrun <= 1'b1;
            end
            if (state_n == ST_ERROR) begin
                cfg_err <= 1'b1;
            end
        end
    end

    assign bus.rd_restart    = restart_q | (state_q == ST_LATCH);
    assign bus.rd_start_addr = (state_q == ST_HEADER) ? 16'h0000 : 16'(start_q);
    assign bus.in_latch      = (state_q == ST_LATCH);
    assign bus.instr_valid   = vld_p1;
    assign bus.instr_data    = data_p1;
    assign bus.scan_done     = done_p1;

endmodule
